tdc_event_packer: RTL

Buffers TDC hit records and serialises them as framed byte packets to the host interface output mux. Sits between the `tdc` core outputs (`detect`/`polarity`/`raw`/`fp`) and the `host_iface` omux port. It replaces the single-record write-out shift register with a record FIFO, a fixed packet framing and loss accounting.

---
 rtl/tdc_event_packer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/tdc_event_packer.sv
// TDC hit record FIFO with fixed byte-packet framing toward the host omux.
// Packet: 0xA5, {lost,seq}, then the record LSB byte first.
module tdc_event_packer #(
    parameter int CHANNEL_COUNT = 2,
    parameter int RAW_COUNT     = 9,
    parameter int FP_COUNT      = 13,
    parameter int DEPTH_LOG2    = 4
) (
    input  logic                              clk_i,
    input  logic                              nreset_i,
    input  logic                              en_i,
    input  logic [CHANNEL_COUNT-1:0]          detect_i,
    input  logic [CHANNEL_COUNT-1:0]          polarity_i,
    input  logic [CHANNEL_COUNT*RAW_COUNT-1:0] raw_i,
    input  logic [CHANNEL_COUNT*FP_COUNT-1:0] fp_i,
    output logic [7:0]                        omux_data_o,
    output logic                              omux_req_o,
    input  logic                              omux_sel_i,
    input  logic                              clr_drop_i,
    output logic [15:0]                       dropped_o,
    output logic [DEPTH_LOG2:0]               level_o
);

    localparam int REC_W = CHANNEL_COUNT * (2 + RAW_COUNT + FP_COUNT);
    localparam int NB    = (REC_W + 7) / 8;
    localparam int P     = NB + 2;
    localparam int PW    = P * 8;
    localparam int IW    = $clog2(P);
    localparam int D     = 1 << DEPTH_LOG2;
    localparam int EW    = REC_W + 8;

    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [IW-1:0]       LAST_IDX = IW'(P - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    logic [EW-1:0]         mem [D];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic [6:0]            seq;
    logic                  lost;
    logic [15:0]           dropped;

    state_t                state;
    state_t                state_nx;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_nx;
    logic [PW-1:0]         pkt;
    logic [PW-1:0]         pkt_nx;
    logic [PW-1:0]         load_pkt;
    logic [NB*8-1:0]       rec_pad;
    logic [EW-1:0]         head;
    logic [REC_W-1:0]      rec;

    logic hit;
    logic full;
    logic empty;
    logic wr;
    logic drop;
    logic pop;

    assign rec   = {polarity_i, detect_i, raw_i, fp_i};
    assign hit   = en_i && (detect_i != '0);
    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);
    // Fullness is judged before any same-cycle pop, so a pop never rescues a write.
    assign wr    = hit && !full;
    assign drop  = hit && full;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (nreset_i && wr) begin
            mem[wr_ptr] <= {lost, seq, rec};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            seq     <= '0;
            lost    <= 1'b0;
            dropped <= '0;
            state   <= IDLE;
            idx     <= '0;
            pkt     <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
                seq    <= seq + 1'b1;
                lost   <= 1'b0;
            end else if (drop) begin
                lost <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !wr) begin
                level <= level - 1'b1;
            end
            if (clr_drop_i) begin
                dropped <= drop ? 16'd1 : 16'd0;
            end else if (drop && dropped != 16'hFFFF) begin
                dropped <= dropped + 1'b1;
            end
            state <= state_nx;
            idx   <= idx_nx;
            pkt   <= pkt_nx;
        end
    end

    always_comb begin
        rec_pad = '0;
        rec_pad[REC_W-1:0] = head[REC_W-1:0];
        load_pkt = {rec_pad, head[EW-1:REC_W], 8'hA5};
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        pkt_nx   = pkt;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pkt_nx   = load_pkt;
                    pop      = 1'b1;
                    idx_nx   = '0;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (omux_sel_i) begin
                    if (idx == LAST_IDX) begin
                        idx_nx = '0;
                        // Chain straight into the next packet to avoid a bubble.
                        if (!empty) begin
                            pkt_nx = load_pkt;
                            pop    = 1'b1;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign omux_req_o  = (state == SEND);
    assign omux_data_o = omux_req_o ? pkt[{idx, 3'b000} +: 8] : 8'h00;
    assign dropped_o   = dropped;
    assign level_o     = level;

endmodule
